gesture_power_timer_ctrl: RTL and testbench

Gesture power-switch controller for the range-hood top level. It is the successor to the fixed 2/5/7/9 s time selector: the four window durations and the clock rate are parameters, and the block runs the countdown itself. It also runs the two-gesture on/off state machine and drives one seven-segment digit, showing either the selected window length or the live seconds remaining.

---
 rtl/gesture_power_timer_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gesture_power_timer_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_power_timer_ctrl.sv
// gesture_power_timer_ctrl
// Two-gesture power switch for the range hood with a built-in confirmation
// window countdown and a single seven-segment digit.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   time_select    window duration select (latched when a window is armed)
//   gesture_left   debounced single-cycle left gesture pulse
//   gesture_right  debounced single-cycle right gesture pulse
//   power_state    1 = hood powered (ON / ARM_OFF)
//   window_active  1 while a confirmation window is armed
//   remaining_sec  whole seconds left in the armed window, 0 otherwise
//   tub_segments   {a,b,c,d,e,f,g,dp}, active-high
//   tub_select     digit enable, held at 1
module gesture_power_timer_ctrl #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned TIME_0   = 2,
  parameter int unsigned TIME_1   = 5,
  parameter int unsigned TIME_2   = 7,
  parameter int unsigned TIME_3   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] time_select,
  input  logic       gesture_left,
  input  logic       gesture_right,
  output logic       power_state,
  output logic       window_active,
  output logic [3:0] remaining_sec,
  output logic [7:0] tub_segments,
  output logic       tub_select
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } state_e;

  // Window length for a given selector value.
  function automatic logic [3:0] dur_of(input logic [1:0] sel);
    case (sel)
      2'b00:   dur_of = 4'(TIME_0);
      2'b01:   dur_of = 4'(TIME_1);
      2'b10:   dur_of = 4'(TIME_2);
      default: dur_of = 4'(TIME_3);
    endcase
  endfunction

  // Digit to segment pattern; anything above 9 blanks the digit.
  function automatic logic [7:0] seg_lut(input logic [3:0] v);
    case (v)
      4'd0:    seg_lut = 8'b1111_1100;
      4'd1:    seg_lut = 8'b0110_0000;
      4'd2:    seg_lut = 8'b1101_1010;
      4'd3:    seg_lut = 8'b1111_0010;
      4'd4:    seg_lut = 8'b0110_0110;
      4'd5:    seg_lut = 8'b1011_0110;
      4'd6:    seg_lut = 8'b1011_1110;
      4'd7:    seg_lut = 8'b1110_0000;
      4'd8:    seg_lut = 8'b1111_1110;
      4'd9:    seg_lut = 8'b1110_0110;
      default: seg_lut = 8'b0000_0000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      rem_q, rem_d;
  logic            power_q, power_d;
  logic            win_q, win_d;
  logic [7:0]      seg_q, seg_d;
  logic            sel_q;

  logic            left_only, right_only, armed, wrap, timeout;
  logic            arm_c;

  // Both pulses high in one cycle count as no gesture.
  assign left_only  = gesture_left & ~gesture_right;
  assign right_only = gesture_right & ~gesture_left;
  assign armed      = (state_q == ST_ARM_ON) || (state_q == ST_ARM_OFF);
  assign wrap       = armed && (presc_q == PRESC_MAX);
  assign timeout    = wrap && (rem_q == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Next state; completing gestures and re-arms take priority over timeout.
  always_comb begin
    state_d = state_q;
    arm_c   = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (left_only) begin
          state_d = ST_ARM_ON;
          arm_c   = 1'b1;
        end
      end
      ST_ARM_ON: begin
        if (right_only)     state_d = ST_ON;
        else if (left_only) arm_c   = 1'b1;
        else if (timeout)   state_d = ST_OFF;
      end
      ST_ON: begin
        if (right_only) begin
          state_d = ST_ARM_OFF;
          arm_c   = 1'b1;
        end
      end
      ST_ARM_OFF: begin
        if (left_only)       state_d = ST_OFF;
        else if (right_only) arm_c   = 1'b1;
        else if (timeout)    state_d = ST_ON;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Output / datapath next values; leaving an armed state clears the window.
  always_comb begin
    presc_d = '0;
    rem_d   = '0;
    if (arm_c) begin
      rem_d = dur_of(time_select);
    end else if ((state_d == ST_ARM_ON) || (state_d == ST_ARM_OFF)) begin
      if (wrap) begin
        rem_d = rem_q - 4'd1;
      end else begin
        presc_d = presc_q + PW'(1);
        rem_d   = rem_q;
      end
    end
    power_d = (state_d == ST_ON) || (state_d == ST_ARM_OFF);
    win_d   = (state_d == ST_ARM_ON) || (state_d == ST_ARM_OFF);
    // Display is driven from registered values, hence one extra cycle.
    seg_d   = seg_lut(win_q ? rem_q : dur_of(time_select));
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      rem_q   <= '0;
      power_q <= 1'b0;
      win_q   <= 1'b0;
      seg_q   <= seg_lut(4'(TIME_1));
      sel_q   <= 1'b1;
    end else begin
      presc_q <= presc_d;
      rem_q   <= rem_d;
      power_q <= power_d;
      win_q   <= win_d;
      seg_q   <= seg_d;
      sel_q   <= 1'b1;
    end
  end

  assign power_state   = power_q;
  assign window_active = win_q;
  assign remaining_sec = rem_q;
  assign tub_segments  = seg_q;
  assign tub_select    = sel_q;

endmodule

// File: tb/tb_gesture_power_timer_ctrl.sv
// Scoreboard bench for gesture_power_timer_ctrl (CLK_FREQ = 10, default TIMEs).
// Stimulus pushes {due cycle, output, expected value}; the monitor compares
// every entry on the falling edge of its due cycle, or at once on sample_ev.
module tb_gesture_power_timer_ctrl;

  localparam logic [2:0] F_POW = 3'd0;
  localparam logic [2:0] F_WIN = 3'd1;
  localparam logic [2:0] F_REM = 3'd2;
  localparam logic [2:0] F_SEG = 3'd3;
  localparam logic [2:0] F_SEL = 3'd4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  fld;
    logic [7:0]  val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] time_select;
  logic       gesture_left, gesture_right;
  logic       power_state, window_active, tub_select;
  logic [3:0] remaining_sec;
  logic [7:0] tub_segments;

  exp_t        sb_q[$];
  logic [31:0] cyc = '0;
  int          checks = 0;
  int          failures = 0;
  event        sample_ev;

  gesture_power_timer_ctrl #(
    .CLK_FREQ(10), .TIME_0(2), .TIME_1(5), .TIME_2(7), .TIME_3(9)
  ) dut (
    .clk(clk), .reset(reset), .time_select(time_select),
    .gesture_left(gesture_left), .gesture_right(gesture_right),
    .power_state(power_state), .window_active(window_active),
    .remaining_sec(remaining_sec), .tub_segments(tub_segments),
    .tub_select(tub_select)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [7:0] actual_of(input logic [2:0] fld);
    case (fld)
      F_POW:   actual_of = {7'd0, power_state};
      F_WIN:   actual_of = {7'd0, window_active};
      F_REM:   actual_of = {4'd0, remaining_sec};
      F_SEG:   actual_of = tub_segments;
      default: actual_of = {7'd0, tub_select};
    endcase
  endfunction

  function automatic string name_of(input logic [2:0] fld);
    case (fld)
      F_POW:   name_of = "power_state";
      F_WIN:   name_of = "window_active";
      F_REM:   name_of = "remaining_sec";
      F_SEG:   name_of = "tub_segments";
      default: name_of = "tub_select";
    endcase
  endfunction

  // Monitor: compare and retire every entry whose due cycle has come.
  always begin
    @(negedge clk or sample_ev);
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        checks++;
        if (sb_q[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s overdue (due cycle %0d, now %0d)", name_of(sb_q[i].fld), sb_q[i].cyc, cyc);
        end else if (actual_of(sb_q[i].fld) !== sb_q[i].val) begin
          failures++;
          $display("FAIL %s cycle %0d got %b want %b", name_of(sb_q[i].fld), cyc,
                   actual_of(sb_q[i].fld), sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input logic [2:0] fld, input logic [7:0] val);
    exp_t e;
    e.cyc = cyc + 32'(off);
    e.fld = fld;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic r);
    gesture_left  = l;
    gesture_right = r;
    tick(1);
    gesture_left  = 1'b0;
    gesture_right = 1'b0;
  endtask

  initial begin
    reset = 1'b0; time_select = 2'b00; gesture_left = 1'b0; gesture_right = 1'b0;

    // Reset state and release.
    tick(1);
    expect_at(1, F_POW, 8'd0);
    expect_at(1, F_WIN, 8'd0);
    expect_at(1, F_REM, 8'd0);
    expect_at(1, F_SEG, 8'b1011_0110);
    expect_at(1, F_SEL, 8'd1);
    tick(2);
    reset = 1'b1;
    expect_at(2, F_SEG, 8'b1101_1010);
    tick(4);

    // Timeout in ARM_ON with D = 2.
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd2);
    expect_at(2, F_SEG, 8'b1101_1010);
    expect_at(11, F_REM, 8'd1);
    expect_at(20, F_REM, 8'd1);
    expect_at(20, F_WIN, 8'd1);
    expect_at(21, F_REM, 8'd0);
    expect_at(21, F_WIN, 8'd0);
    expect_at(21, F_POW, 8'd0);
    expect_at(21, F_SEG, 8'b0110_0000);
    expect_at(22, F_SEG, 8'b1101_1010);
    pulse(1'b1, 1'b0);
    tick(25);

    // Ignored gestures in OFF: both high, right alone.
    expect_at(1, F_WIN, 8'd0);
    expect_at(1, F_POW, 8'd0);
    expect_at(1, F_REM, 8'd0);
    pulse(1'b1, 1'b1);
    expect_at(1, F_WIN, 8'd0);
    expect_at(1, F_POW, 8'd0);
    pulse(1'b0, 1'b1);
    tick(2);

    // Power-on sequence with D = 5.
    time_select = 2'b01;
    tick(2);
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd5);
    expect_at(1, F_POW, 8'd0);
    expect_at(10, F_REM, 8'd5);
    expect_at(11, F_REM, 8'd4);
    expect_at(12, F_SEG, 8'b0110_0110);
    expect_at(20, F_REM, 8'd4);
    expect_at(21, F_REM, 8'd3);
    expect_at(30, F_POW, 8'd0);
    expect_at(31, F_POW, 8'd1);
    expect_at(31, F_WIN, 8'd0);
    expect_at(31, F_REM, 8'd0);
    pulse(1'b1, 1'b0);
    tick(29);
    pulse(1'b0, 1'b1);
    tick(3);

    // Power-off window, time_select changed mid-window, timeout back to ON.
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd5);
    expect_at(1, F_POW, 8'd1);
    expect_at(7, F_SEG, 8'b1011_0110);
    expect_at(21, F_REM, 8'd3);
    expect_at(25, F_POW, 8'd1);
    expect_at(50, F_REM, 8'd1);
    expect_at(50, F_WIN, 8'd1);
    expect_at(51, F_REM, 8'd0);
    expect_at(51, F_WIN, 8'd0);
    expect_at(51, F_POW, 8'd1);
    expect_at(53, F_SEG, 8'b1110_0110);
    pulse(1'b0, 1'b1);
    tick(4);
    time_select = 2'b11;
    tick(50);

    // Left ignored in ON, then ARM_OFF (D = 9) and left -> OFF.
    expect_at(1, F_POW, 8'd1);
    expect_at(1, F_WIN, 8'd0);
    pulse(1'b1, 1'b0);
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd9);
    expect_at(1, F_POW, 8'd1);
    pulse(1'b0, 1'b1);
    tick(2);
    expect_at(1, F_POW, 8'd0);
    expect_at(1, F_WIN, 8'd0);
    expect_at(1, F_REM, 8'd0);
    pulse(1'b1, 1'b0);
    tick(3);

    // Right pulse coinciding with the final wrap in ARM_ON: ends in ON.
    time_select = 2'b00;
    tick(1);
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd2);
    pulse(1'b1, 1'b0);
    tick(19);
    expect_at(0, F_REM, 8'd1);
    expect_at(1, F_POW, 8'd1);
    expect_at(1, F_WIN, 8'd0);
    expect_at(1, F_REM, 8'd0);
    pulse(1'b0, 1'b1);
    tick(3);

    // Asynchronous reset in ARM_OFF with remaining_sec = 3.
    time_select = 2'b01;
    tick(1);
    expect_at(1, F_POW, 8'd1);
    expect_at(1, F_WIN, 8'd1);
    expect_at(1, F_REM, 8'd5);
    pulse(1'b0, 1'b1);
    tick(23);
    expect_at(0, F_REM, 8'd3);
    expect_at(0, F_POW, 8'd1);
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    expect_at(0, F_POW, 8'd0);
    expect_at(0, F_WIN, 8'd0);
    expect_at(0, F_REM, 8'd0);
    expect_at(0, F_SEG, 8'b1011_0110);
    expect_at(0, F_SEL, 8'd1);
    -> sample_ev;
    tick(2);
    reset = 1'b1;
    tick(3);

    // Anything never compared is a failure.
    foreach (sb_q[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never compared (due cycle %0d)", name_of(sb_q[i].fld), sb_q[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
